// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared defaults and width helper for the round-robin stream multiplexer
package stream_mux_pkg;

  localparam int default_bitwidth = 8;
  localparam int default_inputs   = 4;

  // Index fields must stay at least one bit wide, even for a single source.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: priority pointer, wrapping search, one-hot and index grant
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int n = default_inputs,
  parameter int w = clog2_min1(n)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] request,
  input  logic         advance,
  output logic [n-1:0] grant_onehot,
  output logic [w-1:0] grant_idx,
  output logic         grant_valid
);

  logic [w-1:0] last_grant;

  // Pointer resets to the top index so source 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= w'(n - 1);
    end else if (advance && grant_valid) begin
      last_grant <= grant_idx;
    end
  end

  // Search order is last_grant+1, last_grant+2, ... modulo n; the first requester wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    for (int k = 1; k <= n; k++) begin
      for (int j = 0; j < n; j++) begin
        if (!grant_valid && request[j] && (j == (int'(last_grant) + k) % n)) begin
          grant_valid     = 1'b1;
          grant_onehot[j] = 1'b1;
          grant_idx       = w'(j);
        end
      end
    end
  end

endmodule

// File: rtl/stream_multiplexer_rr.sv
// rtl/stream_multiplexer_rr.sv - merges valid/ready streams round-robin into one registered output
module stream_multiplexer_rr
  import stream_mux_pkg::*;
#(
  parameter int in_bitwidth = default_bitwidth,
  parameter int in_inputs   = default_inputs,
  parameter int log2ofin    = clog2_min1(in_inputs)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [in_bitwidth-1:0] in_data [in_inputs],
  input  logic [in_inputs-1:0]   in_valid,
  output logic [in_inputs-1:0]   in_ready,
  output logic [in_bitwidth-1:0] out_data,
  output logic [log2ofin-1:0]    out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic                   load_en;
  logic                   accept;
  logic [in_inputs-1:0]   grant_onehot;
  logic [log2ofin-1:0]    grant_idx;
  logic                   grant_valid;
  logic [in_bitwidth-1:0] sel_data;

  assign load_en  = !out_valid || out_ready;
  assign accept   = load_en && !rst;
  assign in_ready = accept ? grant_onehot : '0;

  rr_arbiter #(
    .n (in_inputs),
    .w (log2ofin)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .request      (in_valid),
    .advance      (accept),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid)
  );

  // AND-OR mux on the one-hot grant keeps indexing inside the source array.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < in_inputs; i++) begin
      if (grant_onehot[i]) sel_data = sel_data | in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_multiplexer_rr.md
STREAM_MULTIPLEXER_RR -- requirements
Module: stream_multiplexer_rr

Interface
REQ-001 Parameter in_bitwidth, default 8: width of each data word.
REQ-002 Parameter in_inputs, default 4: number of input streams; legal range 1..16.
REQ-003 Parameter log2ofin, default $clog2(in_inputs), forced to 1 when in_inputs is 1: width of the source-index field.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_data, input, unpacked array [in_inputs] of in_bitwidth: per-source data words.
REQ-007 Port in_valid, input, in_inputs: per-source valid.
REQ-008 Port in_ready, output, in_inputs: per-source ready; one-hot or zero.
REQ-009 Port out_data, output, in_bitwidth: registered merged data.
REQ-010 Port out_sel, output, log2ofin: registered index of the source that supplied out_data.
REQ-011 Port out_valid, output, 1: out_data/out_sel hold a word.
REQ-012 Port out_ready, input, 1: downstream accepts the word.

Function
REQ-013 The block SHALL merge in_inputs valid/ready streams into one output stream through a single output register, with a 1-cycle latency from input transfer to out_valid.
REQ-014 A transfer on source i SHALL occur when in_valid[i] and in_ready[i] are both high on a rising edge; output transfer occurs when out_valid and out_ready are both high.
REQ-015 The register SHALL load (load_en) when out_valid is low or out_ready is high, allowing full throughput of one word per cycle.
REQ-016 Grant SHALL be round-robin: search begins at index (last_grant+1) mod in_inputs and wraps; the first index with in_valid high wins.
REQ-017 in_ready[i] SHALL be high only when i is the current winner and load_en is high; in_ready SHALL be combinational from in_valid, last_grant, out_valid, and out_ready.
REQ-018 last_grant SHALL update to the winner only on a completed input transfer; otherwise it is held.
REQ-019 On load with a winner: out_data <= in_data[winner], out_sel <= winner, out_valid <= 1.
REQ-020 On load with no input valid: out_valid <= 0; out_data and out_sel are held.
REQ-021 While out_valid is high and out_ready is low, out_data, out_sel, and out_valid SHALL remain stable and all in_ready SHALL be low.
REQ-022 With in_inputs not a power of 2, the pointer SHALL wrap from in_inputs-1 to 0 and never index beyond in_inputs-1.
REQ-023 With in_inputs equal to 1, the block SHALL degenerate to a 1-deep pipeline register with out_sel constant 0.

Reset
REQ-024 When rst is high on a rising edge: out_valid <= 0, out_data <= 0, out_sel <= 0, last_grant <= in_inputs-1, so source 0 has first priority.
REQ-025 During reset, in_ready SHALL be all-zero.
REQ-026 Reset during a stalled output SHALL discard the held word without an output transfer.

Structure
REQ-027 Package stream_mux_pkg SHALL hold the defaults (default in_bitwidth, default in_inputs) and the guarded clog2 helper function.
REQ-028 Sub-module rr_arbiter SHALL implement the pointer, the wrap search, and the one-hot grant plus grant index, parameterised on in_inputs.
REQ-029 Sub-module rr_arbiter SHALL expose request, advance (transfer), grant_onehot, and grant_idx.
REQ-030 The top level SHALL hold only the output register and the handshake logic.

Verification
REQ-031 Reset, then all in_valid low for 3 cycles -> out_valid 0, in_ready 0000, out_data 0.
REQ-032 in_inputs=4, all valid, data 8'hA0..8'hA3, out_ready constantly 1 -> out_sel 0,1,2,3,0,... on consecutive cycles, starting 1 cycle after the first edge.
REQ-033 Only source 2 valid with 8'h5C, out_ready low for 4 cycles -> out_data 8'h5C and out_sel 2 held stable, in_ready 0000 until out_ready rises, then exactly one transfer.
REQ-034 in_inputs=3, sources 0 and 2 valid, last_grant 2 -> grant 0, then 2, then 0; out_sel never reaches 3.
REQ-035 rst asserted while out_valid=1 and out_ready=0 -> the next cycle shows out_valid 0 and out_sel 0, and the first grant after reset goes to source 0.
REQ-036 Random valid/ready stress over 10k cycles -> per-source order preserved, no loss or duplication, and no source starved more than in_inputs-1 grants.
